// File: rtl/im_loader.sv
// Byte-stream instruction-memory loader: 16-bit big-endian word count header
// followed by big-endian 32-bit words, each written to consecutive word addresses.
module im_loader #(
   parameter int unsigned MAX_WORDS = 64,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   typedef enum logic [2:0] {
      IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
   } state_t;

   state_t        state, nxt;
   logic [7:0]    count_hi;
   logic [15:0]   count;
   logic [15:0]   hdr;
   logic [IW-1:0] idx;
   logic [1:0]    nbytes;
   logic [23:0]   partial;
   logic          accept;
   logic          last_word;

   assign accept    = rx_valid && rx_ready;
   assign hdr       = {count_hi, rx_data};
   assign last_word = (32'(idx) + 32'd1 == 32'(count));

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) nxt = HDR_HI;
         HDR_HI:          if (accept) nxt = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr == 16'd0)                  nxt = DONE;
               else if (32'(hdr) > MAX_WORDS)     nxt = ERR;
               else                               nxt = DATA;
            end
         end
         DATA:            if (accept && nbytes == 2'd3) nxt = WRITE;
         WRITE:           nxt = last_word ? DONE : DATA;
         default:         nxt = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rx_ready <= 1'b0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         count_hi <= '0;
         count    <= '0;
         idx      <= '0;
         nbytes   <= '0;
         partial  <= '0;
      end else begin
         state    <= nxt;
         rx_ready <= (nxt == HDR_HI) || (nxt == HDR_LO) || (nxt == DATA);
         busy     <= (nxt == HDR_HI) || (nxt == HDR_LO) || (nxt == DATA) || (nxt == WRITE);
         im_we    <= (nxt == WRITE);
         done     <= (nxt == DONE);
         error    <= (nxt == ERR);
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  idx    <= '0;
                  nbytes <= '0;
               end
            end
            HDR_HI: if (accept) count_hi <= rx_data;
            HDR_LO: if (accept) count <= hdr;
            DATA: begin
               if (accept) begin
                  nbytes  <= nbytes + 2'd1;
                  partial <= {partial[15:0], rx_data};
                  if (nbytes == 2'd3) begin
                     im_wdata <= {partial, rx_data};
                     im_addr  <= 32'(idx) * ADDR_STEP;
                  end
               end
            end
            // Index stays on the final word so it never reaches MAX_WORDS.
            WRITE: if (!last_word) idx <= idx + IW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: a session-level reference model predicts every
// output each cycle; a few literal checks pin the model on the canonical sessions.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic        busy;
   logic        done;
   logic        error;

   im_loader #(.MAX_WORDS(64), .ADDR_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [63:0] wlog[$];

   // Session model: how many bytes accepted, header count, words written so far.
   logic        m_active = 0, m_done = 0, m_err = 0, m_we = 0;
   int unsigned m_k = 0, m_cnt = 0, m_wr = 0;
   logic [31:0] m_addr = '0, m_data = '0, m_shift = '0;
   logic [15:0] m_hdr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rx_ready", 32'(rx_ready), 0);
         chk("rst_im_we",    32'(im_we), 0);
         chk("rst_busy",     32'(busy), 0);
         chk("rst_done",     32'(done), 0);
         chk("rst_error",    32'(error), 0);
         chk("rst_im_addr",  im_addr, 0);
         chk("rst_im_wdata", im_wdata, 0);
         m_active = 0; m_done = 0; m_err = 0; m_we = 0;
         m_k = 0; m_cnt = 0; m_wr = 0; m_addr = '0; m_data = '0;
      end else begin
         chk("rx_ready", 32'(rx_ready), 32'(m_active && !m_we));
         chk("busy",     32'(busy), 32'(m_active));
         chk("done",     32'(done), 32'(m_done));
         chk("error",    32'(error), 32'(m_err));
         chk("im_we",    32'(im_we), 32'(m_we));
         chk("im_addr",  im_addr, m_addr);
         chk("im_wdata", im_wdata, m_data);
         if (im_we) wlog.push_back({im_addr, im_wdata});
         // advance the model with the inputs that the next rising edge will see
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_done = 0; m_err = 0; m_k = 0; m_wr = 0;
            end
         end else if (m_we) begin
            m_we = 0;
            m_wr++;
            if (m_wr == m_cnt) begin m_active = 0; m_done = 1; end
         end else if (rx_valid) begin
            m_k++;
            if (m_k <= 2) begin
               m_hdr = {m_hdr[7:0], rx_data};
               if (m_k == 2) begin
                  m_cnt = 32'(m_hdr);
                  if (m_cnt == 0) begin m_active = 0; m_done = 1; end
                  else if (m_cnt > 64) begin m_active = 0; m_err = 1; end
               end
            end else begin
               m_shift = {m_shift[23:0], rx_data};
               if ((m_k - 2) % 4 == 0) begin
                  m_we = 1; m_data = m_shift; m_addr = m_wr * 4;
               end
            end
         end
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
      int unsigned gap, tries;
      gap = $urandom_range(maxgap, 0);
      repeat (gap) begin
         rx_valid = 1'b0; rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b1; rx_data = b; tries = 0;
      forever begin
         @(negedge clk);
         if (rx_ready) break;
         tries++;
         if (tries > 40) begin
            miscompares++;
            $display("FAIL accept_timeout: got no rx_ready expected acceptance of %h", b);
            break;
         end
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic offer_junk(input int unsigned n);
      repeat (n) begin
         rx_valid = 1'b1; rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_words(input int unsigned nw, input int unsigned maxgap);
      repeat (nw * 4) send_byte(8'($urandom), maxgap);
   endtask

   initial begin
      int unsigned n0;
      logic [7:0] s1 [10];
      s1 = '{8'h00, 8'h02, 8'h21, 8'h08, 8'h00, 8'h02, 8'h21, 8'h4A, 8'h00, 8'h02};
      idle(3);
      #2 rst_n = 1'b1;
      idle(2);
      @(negedge clk);
      chk("lit_reset_busy", 32'(busy), 0);
      chk("lit_reset_rdy", 32'(rx_ready), 0);
      idle(1);

      // Two-word program
      n0 = wlog.size();
      do_start();
      foreach (s1[i]) send_byte(s1[i], 0);
      idle(2);
      @(negedge clk);
      chk("lit_s1_nwrites", wlog.size() - n0, 2);
      chk("lit_s1_addr0", wlog[n0][63:32], 32'h0);
      chk("lit_s1_data0", wlog[n0][31:0], 32'h21080002);
      chk("lit_s1_addr1", wlog[n0+1][63:32], 32'h4);
      chk("lit_s1_data1", wlog[n0+1][31:0], 32'h214A0002);
      chk("lit_s1_done", 32'(done), 1);
      chk("lit_s1_busy", 32'(busy), 0);
      idle(1);
      offer_junk(3);

      // Empty program: done two cycles after start
      n0 = wlog.size();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      chk("lit_zero_done", 32'(done), 1);
      chk("lit_zero_nwrites", wlog.size() - n0, 0);
      idle(1);

      // Oversized header
      n0 = wlog.size();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h41, 0);
      offer_junk(4);
      @(negedge clk);
      chk("lit_err_error", 32'(error), 1);
      chk("lit_err_rdy", 32'(rx_ready), 0);
      chk("lit_err_nwrites", wlog.size() - n0, 0);
      idle(1);
      do_start();
      @(negedge clk);
      chk("lit_err_cleared", 32'(error), 0);
      idle(1);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      idle(2);

      // Full memory with random gaps
      n0 = wlog.size();
      do_start();
      send_byte(8'h00, 2);
      send_byte(8'h40, 2);
      send_words(64, 3);
      idle(2);
      @(negedge clk);
      chk("lit_full_nwrites", wlog.size() - n0, 64);
      chk("lit_full_last_addr", wlog[wlog.size()-1][63:32], 32'hFC);
      chk("lit_full_done", 32'(done), 1);
      idle(1);

      // start during DATA is ignored
      n0 = wlog.size();
      do_start();
      send_byte(8'h00, 1);
      send_byte(8'h03, 1);
      send_words(1, 1);
      send_byte(8'h5A, 1);
      do_start();
      repeat (7) send_byte(8'($urandom), 1);
      idle(2);
      @(negedge clk);
      chk("lit_ign_nwrites", wlog.size() - n0, 3);
      chk("lit_ign_done", 32'(done), 1);
      idle(1);

      // Reset mid-word
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hEE, 0);
      send_byte(8'hDD, 0);
      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      n0 = wlog.size();
      idle(4);
      @(negedge clk);
      chk("lit_rst_nowrite", wlog.size() - n0, 0);
      idle(1);
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hA1, 1);
      send_byte(8'hB2, 1);
      send_byte(8'hC3, 1);
      send_byte(8'hD4, 1);
      idle(2);
      @(negedge clk);
      chk("lit_rst_nwrites", wlog.size() - n0, 1);
      chk("lit_rst_addr", wlog[n0][63:32], 32'h0);
      chk("lit_rst_data", wlog[n0][31:0], 32'hA1B2C3D4);
      idle(1);

      // Random sessions
      repeat (8) begin
         int unsigned cnt;
         cnt = $urandom_range(6, 1);
         do_start();
         send_byte(8'h00, 2);
         send_byte(8'(cnt), 2);
         send_words(cnt, 3);
         idle($urandom_range(3, 1));
         offer_junk($urandom_range(2, 0));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
